avalon_burst_master: RTL and testbench



---
 rtl/avalon_burst_master.sv | 99 +++++++++
 tb/tb_avalon_burst_master.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_burst_master.sv
// avalon_burst_master: Avalon-MM burst master with streamed writes and a credit-gated read FIFO
module avalon_burst_master #(
  parameter int DATA_W        = 128,
  parameter int ADDR_W        = 32,
  parameter int BURST_W       = 7,
  parameter int MAX_BURST     = 64,
  parameter int RD_FIFO_DEPTH = 128
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_address,
  input  logic [BURST_W-1:0]  cmd_len,
  output logic                cmd_err,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [DATA_W-1:0]   wr_data,
  output logic                wr_done,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [DATA_W-1:0]   rd_data,
  output logic                busy,
  output logic [ADDR_W-1:0]   avm_m0_address,
  output logic                avm_m0_read,
  output logic                avm_m0_write,
  output logic [DATA_W-1:0]   avm_m0_writedata,
  output logic [DATA_W/8-1:0] avm_m0_byteenable,
  output logic [BURST_W-1:0]  avm_m0_burstcount,
  input  logic [DATA_W-1:0]   avm_m0_readdata,
  input  logic                avm_m0_readdatavalid,
  input  logic                avm_m0_waitrequest
);
  localparam int CW = $clog2(RD_FIFO_DEPTH) + 1;
  localparam int PW = $clog2(RD_FIFO_DEPTH);
  localparam int SW = (CW > BURST_W ? CW : BURST_W) + 1;
  typedef enum logic [1:0] {IDLE, WR_BURST, RD_CMD} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [BURST_W-1:0] len_q, beat_cnt;
  logic [CW-1:0] outstanding, fifo_count;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [DATA_W-1:0] mem [RD_FIFO_DEPTH];
  logic len_bad, credit_ok, accept, beat, last_beat, push, pop, active;
  assign len_bad   = cmd_len == '0 || cmd_len > BURST_W'(MAX_BURST);
  // reads must leave room for every beat already owed plus the new burst
  assign credit_ok = SW'(fifo_count) + SW'(outstanding) + SW'(cmd_len) <= SW'(RD_FIFO_DEPTH);
  assign cmd_ready = !reset && state == IDLE && (cmd_write || len_bad || credit_ok);
  assign accept    = cmd_valid && cmd_ready;
  assign beat      = state == WR_BURST && wr_valid && !avm_m0_waitrequest;
  assign last_beat = beat && beat_cnt == len_q - BURST_W'(1);
  assign push      = avm_m0_readdatavalid && outstanding != '0;
  assign pop       = rd_valid && rd_ready;
  assign active    = state != IDLE;
  assign avm_m0_write      = state == WR_BURST && wr_valid;
  assign avm_m0_read       = state == RD_CMD;
  assign avm_m0_address    = active ? addr_q : '0;
  assign avm_m0_burstcount = active ? len_q : '0;
  assign avm_m0_writedata  = avm_m0_write ? wr_data : '0;
  assign avm_m0_byteenable = (avm_m0_write || avm_m0_read) ? '1 : '0;
  assign wr_ready = state == WR_BURST && !avm_m0_waitrequest;
  assign rd_valid = fifo_count != '0;
  assign rd_data  = mem[rd_ptr];
  assign busy     = active || outstanding != '0 || rd_valid;
  always_comb begin
    state_nx = state == IDLE     ? (accept && !len_bad ? (cmd_write ? WR_BURST : RD_CMD) : IDLE)
             : state == WR_BURST ? (last_beat ? IDLE : WR_BURST)
             :                     (avm_m0_waitrequest ? RD_CMD : IDLE);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      beat_cnt    <= '0;
      outstanding <= '0;
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      wr_done     <= 1'b0;
      cmd_err     <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        addr_q   <= cmd_address;
        len_q    <= cmd_len;
        beat_cnt <= '0;
      end else if (beat) beat_cnt <= beat_cnt + BURST_W'(1);
      wr_done     <= last_beat;
      cmd_err     <= accept && len_bad;
      outstanding <= outstanding + (accept && !cmd_write && !len_bad ? CW'(cmd_len) : '0) - CW'(push);
      fifo_count  <= fifo_count + CW'(push) - CW'(pop);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
    end
  end
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= avm_m0_readdata;
endmodule

// File: tb/tb_avalon_burst_master.sv
// tb_avalon_burst_master: directed checks of write streaming, read FIFO, credit gating and reset
module tb_avalon_burst_master;
  localparam int DW = 32, AW = 32, BW = 7;
  logic clk = 1'b0, reset;
  logic cmd_valid, cmd_ready, cmd_write, cmd_err;
  logic [AW-1:0] cmd_address;
  logic [BW-1:0] cmd_len;
  logic wr_valid, wr_ready, wr_done, rd_valid, rd_ready, busy;
  logic [DW-1:0] wr_data, rd_data;
  logic [AW-1:0] avm_m0_address;
  logic avm_m0_read, avm_m0_write, avm_m0_readdatavalid, avm_m0_waitrequest;
  logic [DW-1:0] avm_m0_writedata, avm_m0_readdata;
  logic [DW/8-1:0] avm_m0_byteenable;
  logic [BW-1:0] avm_m0_burstcount;
  int checks = 0, errors = 0;
  logic [DW-1:0] wq[$], rq[$];

  avalon_burst_master #(.DATA_W(DW), .ADDR_W(AW), .BURST_W(BW), .MAX_BURST(16), .RD_FIFO_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_address(cmd_address), .cmd_len(cmd_len), .cmd_err(cmd_err), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_data(wr_data), .wr_done(wr_done), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .busy(busy), .avm_m0_address(avm_m0_address), .avm_m0_read(avm_m0_read),
    .avm_m0_write(avm_m0_write), .avm_m0_writedata(avm_m0_writedata), .avm_m0_byteenable(avm_m0_byteenable),
    .avm_m0_burstcount(avm_m0_burstcount), .avm_m0_readdata(avm_m0_readdata),
    .avm_m0_readdatavalid(avm_m0_readdatavalid), .avm_m0_waitrequest(avm_m0_waitrequest));

  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (avm_m0_write && !avm_m0_waitrequest) wq.push_back(avm_m0_writedata);
    if (rd_valid && rd_ready) rq.push_back(rd_data);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_len = 7'd4;
    tick; tick;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready got %b want 0", cmd_ready); end
    checks++; if ({avm_m0_read, avm_m0_write, avm_m0_byteenable, avm_m0_burstcount, avm_m0_address, avm_m0_writedata} !== '0) begin
      errors++; $display("FAIL reset_avm got r%b w%b be%h bc%0d a%h want all 0", avm_m0_read, avm_m0_write, avm_m0_byteenable, avm_m0_burstcount, avm_m0_address);
    end
    checks++; if ({wr_ready, rd_valid, wr_done, cmd_err, busy} !== 5'b0) begin
      errors++; $display("FAIL reset_status got %b want 00000", {wr_ready, rd_valid, wr_done, cmd_err, busy});
    end
    cmd_valid = 1'b0; reset = 1'b0;
    tick;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL idle_write_ready got %b want 1", cmd_ready); end
  endtask

  task automatic test_write_burst;
    wq.delete();
    cmd_address = 32'h100; cmd_len = 7'd4; cmd_write = 1'b1; cmd_valid = 1'b1; wr_valid = 1'b1; wr_data = 32'hA0;
    tick;
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_data = DW'(32'hA0 + i);
      #1;
      checks++;
      if ({avm_m0_write, avm_m0_address, avm_m0_burstcount, avm_m0_writedata, avm_m0_byteenable, wr_done} !== {1'b1, 32'h100, 7'd4, DW'(32'hA0 + i), 4'hF, 1'b0}) begin
        errors++; $display("FAIL wr4_beat%0d got w%b a%h bc%0d d%h be%h done%b want w1 a100 bc4 d%h beF done0",
          i, avm_m0_write, avm_m0_address, avm_m0_burstcount, avm_m0_writedata, avm_m0_byteenable, wr_done, 32'hA0 + i);
      end
      tick;
    end
    checks++; if ({wr_done, avm_m0_write} !== 2'b10) begin errors++; $display("FAIL wr4_done got done%b w%b want done1 w0", wr_done, avm_m0_write); end
    wr_valid = 1'b0;
    tick;
    checks++; if (wr_done !== 1'b0) begin errors++; $display("FAIL wr4_done_pulse got %b want 0", wr_done); end
    checks++; if (wq.size() != 4) begin errors++; $display("FAIL wr4_count got %0d want 4", wq.size()); end
    else for (int i = 0; i < 4; i++) begin
      checks++; if (wq[i] !== DW'(32'hA0 + i)) begin errors++; $display("FAIL wr4_data%0d got %h want %h", i, wq[i], 32'hA0 + i); end
    end
  endtask

  task automatic test_write_stall;
    bit wv[6] = '{1, 1, 1, 1, 0, 1};
    bit wt[6] = '{0, 1, 1, 0, 0, 0};
    int di[6] = '{0, 1, 1, 1, 2, 2};
    wq.delete();
    cmd_address = 32'h200; cmd_len = 7'd3; cmd_write = 1'b1; cmd_valid = 1'b1; wr_valid = 1'b0;
    tick;
    cmd_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      wr_valid = wv[c]; avm_m0_waitrequest = wt[c]; wr_data = DW'(32'hB0 + di[c]);
      #1;
      checks++;
      if ({wr_ready, avm_m0_write, avm_m0_address} !== {!wt[c], wv[c], 32'h200}) begin
        errors++; $display("FAIL wr3_cycle%0d got rdy%b w%b a%h want rdy%b w%b a200", c, wr_ready, avm_m0_write, avm_m0_address, !wt[c], wv[c]);
      end
      tick;
    end
    checks++; if (wr_done !== 1'b1) begin errors++; $display("FAIL wr3_done got %b want 1", wr_done); end
    avm_m0_waitrequest = 1'b0; wr_valid = 1'b0;
    checks++; if (wq.size() != 3) begin errors++; $display("FAIL wr3_count got %0d want 3", wq.size()); end
    else for (int i = 0; i < 3; i++) begin
      checks++; if (wq[i] !== DW'(32'hB0 + i)) begin errors++; $display("FAIL wr3_data%0d got %h want %h", i, wq[i], 32'hB0 + i); end
    end
    tick;
  endtask

  task automatic test_read_pair;
    int sent = 0;
    rq.delete();
    cmd_address = 32'h1000; cmd_len = 7'd8; cmd_write = 1'b0; cmd_valid = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rd1_ready got %b want 1", cmd_ready); end
    tick;
    avm_m0_waitrequest = 1'b1; cmd_address = 32'h2000;
    #1;
    checks++; if ({avm_m0_read, avm_m0_address, avm_m0_burstcount, cmd_ready} !== {1'b1, 32'h1000, 7'd8, 1'b0}) begin
      errors++; $display("FAIL rd1_issue got r%b a%h bc%0d rdy%b want r1 a1000 bc8 rdy0", avm_m0_read, avm_m0_address, avm_m0_burstcount, cmd_ready);
    end
    tick;
    checks++; if ({avm_m0_read, avm_m0_address} !== {1'b1, 32'h1000}) begin errors++; $display("FAIL rd1_hold got r%b a%h want r1 a1000", avm_m0_read, avm_m0_address); end
    avm_m0_waitrequest = 1'b0;
    tick;
    checks++; if ({avm_m0_read, cmd_ready} !== 2'b01) begin errors++; $display("FAIL rd2_ready got r%b rdy%b want r0 rdy1", avm_m0_read, cmd_ready); end
    tick;
    checks++; if ({avm_m0_read, avm_m0_address, avm_m0_burstcount, busy} !== {1'b1, 32'h2000, 7'd8, 1'b1}) begin
      errors++; $display("FAIL rd2_issue got r%b a%h bc%0d busy%b want r1 a2000 bc8 busy1", avm_m0_read, avm_m0_address, avm_m0_burstcount, busy);
    end
    cmd_valid = 1'b0;
    tick;
    for (int c = 0; c < 80 && rq.size() < 16; c++) begin
      avm_m0_readdatavalid = sent < 16 && c % 3 != 2;
      avm_m0_readdata = DW'(32'h5000 + sent);
      rd_ready = c[0];
      if (c == 0) begin
        #1;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rd_latency_pre got %b want 0", rd_valid); end
      end
      tick;
      if (avm_m0_readdatavalid) sent++;
      if (c == 0) begin
        checks++; if ({rd_valid, rd_data} !== {1'b1, 32'h5000}) begin errors++; $display("FAIL rd_latency got v%b d%h want v1 d5000", rd_valid, rd_data); end
      end
    end
    avm_m0_readdatavalid = 1'b0; rd_ready = 1'b0;
    checks++; if (rq.size() != 16) begin errors++; $display("FAIL rd16_count got %0d want 16", rq.size()); end
    else for (int i = 0; i < 16; i++) begin
      checks++; if (rq[i] !== DW'(32'h5000 + i)) begin errors++; $display("FAIL rd16_data%0d got %h want %h", i, rq[i], 32'h5000 + i); end
    end
    checks++; if ({busy, rd_valid} !== 2'b00) begin errors++; $display("FAIL rd16_idle got busy%b v%b want 00", busy, rd_valid); end
  endtask

  task automatic test_credit;
    rq.delete();
    cmd_address = 32'h3000; cmd_len = 7'd12; cmd_write = 1'b0; cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0;
    tick;
    for (int i = 0; i < 12; i++) begin
      avm_m0_readdatavalid = 1'b1; avm_m0_readdata = DW'(32'h6000 + i);
      tick;
    end
    avm_m0_readdatavalid = 1'b0;
    cmd_len = 7'd8; cmd_valid = 1'b1;
    #1;
    checks++; if ({cmd_ready, rd_data, busy} !== {1'b0, 32'h6000, 1'b1}) begin
      errors++; $display("FAIL credit_full got rdy%b d%h busy%b want rdy0 d6000 busy1", cmd_ready, rd_data, busy);
    end
    rd_ready = 1'b1;
    tick; tick; tick;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL credit_9 got %b want 0", cmd_ready); end
    tick;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL credit_8 got %b want 1", cmd_ready); end
    cmd_valid = 1'b0; rd_ready = 1'b0;
    tick;
    rd_ready = 1'b1;
    for (int c = 0; c < 20 && rd_valid; c++) tick;
    rd_ready = 1'b0;
    checks++; if (rq.size() != 12) begin errors++; $display("FAIL credit_count got %0d want 12", rq.size()); end
    else for (int i = 0; i < 12; i++) begin
      checks++; if (rq[i] !== DW'(32'h6000 + i)) begin errors++; $display("FAIL credit_data%0d got %h want %h", i, rq[i], 32'h6000 + i); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL credit_busy got %b want 0", busy); end
  endtask

  task automatic test_invalid;
    logic [BW-1:0] lens[3] = '{7'd0, 7'd17, 7'd65};
    bit wrs[3] = '{0, 1, 0};
    for (int i = 0; i < 3; i++) begin
      cmd_len = lens[i]; cmd_write = wrs[i]; cmd_valid = 1'b1;
      #1;
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL bad%0d_ready got %b want 1", lens[i], cmd_ready); end
      tick;
      cmd_valid = 1'b0;
      #1;
      checks++; if ({cmd_err, avm_m0_read, avm_m0_write, busy} !== 4'b1000) begin
        errors++; $display("FAIL bad%0d_err got err%b r%b w%b busy%b want 1000", lens[i], cmd_err, avm_m0_read, avm_m0_write, busy);
      end
      tick;
      checks++; if ({cmd_err, avm_m0_read, avm_m0_write} !== 3'b000) begin
        errors++; $display("FAIL bad%0d_pulse got err%b r%b w%b want 000", lens[i], cmd_err, avm_m0_read, avm_m0_write);
      end
    end
  endtask

  task automatic test_reset_inflight;
    cmd_address = 32'h4000; cmd_len = 7'd5; cmd_write = 1'b0; cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0;
    tick;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_rd_busy got %b want 1", busy); end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_rd_cleared got %b want 0", busy); end
    rd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      avm_m0_readdatavalid = 1'b1; avm_m0_readdata = DW'(32'h7000 + i);
      tick;
      checks++; if ({rd_valid, busy} !== 2'b00) begin errors++; $display("FAIL rst_rd_beat%0d got v%b busy%b want 00", i, rd_valid, busy); end
    end
    avm_m0_readdatavalid = 1'b0; rd_ready = 1'b0;
    cmd_address = 32'h500; cmd_len = 7'd4; cmd_write = 1'b1; cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0; wr_valid = 1'b1; wr_data = 32'hC0;
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0; wr_valid = 1'b0;
    #1;
    checks++; if ({avm_m0_write, wr_ready, cmd_ready, wr_done} !== 4'b0010) begin
      errors++; $display("FAIL rst_wr got w%b rdy%b cmdrdy%b done%b want 0010", avm_m0_write, wr_ready, cmd_ready, wr_done);
    end
    tick;
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    avm_m0_readdata = '0; avm_m0_readdatavalid = 1'b0; avm_m0_waitrequest = 1'b0;
    test_reset;
    test_write_burst;
    test_write_stall;
    test_read_pair;
    test_credit;
    test_invalid;
    test_reset_inflight;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
